count_compare_irq: RTL and testbench

- Consumer stage placed directly downstream of the free-running counter; it takes the counter's `count` bus as input.
- Compares `count` against a programmable compare register and raises a level interrupt on match.
- The interrupt is held until the CPU acknowledges it. Matches that arrive while an interrupt is already pending are counted as misses.
- Also flags the counter's wrap-around (all-ones to zero) with a one-cycle pulse.

---
 rtl/count_cmp_pkg.sv | 13 +
 rtl/count_wrap_detect.sv | 32 +++
 rtl/count_compare_irq.sv | 120 ++++++++++++
 tb/tb_count_compare_irq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/count_cmp_pkg.sv
// Shared state encoding and default widths for the count/compare interrupt block.
package count_cmp_pkg;

   localparam int COUNT_LENGTH_DEFAULT = 10;
   localparam int MISS_W_DEFAULT       = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      PENDING = 2'd2
   } cmp_state_e;

endpackage

// File: rtl/count_wrap_detect.sv
// Registers the upstream count and flags an all-ones to zero step with a one-cycle pulse.
// A jump to zero from any other value (upstream reset) is deliberately not a wrap.
module count_wrap_detect
   import count_cmp_pkg::*;
#(
   parameter int LENGTH = COUNT_LENGTH_DEFAULT
) (
   input  logic              clk,
   input  logic              arst_b,
   input  logic [LENGTH-1:0] count,
   output logic              wrap
);

   logic [LENGTH-1:0] count_prev_q;
   logic              wrap_q;
   logic              wrap_d;

   assign wrap_d = (count_prev_q == {LENGTH{1'b1}}) && (count == '0);

   always_ff @(posedge clk or negedge arst_b) begin
      if (!arst_b) begin
         count_prev_q <= '0;
         wrap_q       <= 1'b0;
      end else begin
         count_prev_q <= count;
         wrap_q       <= wrap_d;
      end
   end

   assign wrap = wrap_q;

endmodule

// File: rtl/count_compare_irq.sv
// Compare stage behind the free-running counter: level irq on match, saturating miss count, wrap pulse.
// Build option COUNT_CMP_AUTO_RELOAD_EN: periodic compare (cmp_reg += period_reg) and ack re-arms.
module count_compare_irq
   import count_cmp_pkg::*;
#(
   parameter int LENGTH = COUNT_LENGTH_DEFAULT,
   parameter int MISS_W = MISS_W_DEFAULT
) (
   input  logic              clk,
   input  logic              arst_b,
   input  logic [LENGTH-1:0] count,
   input  logic [LENGTH-1:0] cmp_value,
   input  logic              cmp_load,
   input  logic              arm,
   input  logic              disarm,
   input  logic              irq_ack,
   output logic              irq,
   output logic              wrap,
   output logic [MISS_W-1:0] miss_count,
   output logic [1:0]        state
);

   localparam logic [MISS_W-1:0] MISS_MAX = '1;
`ifdef COUNT_CMP_AUTO_RELOAD_EN
   localparam cmp_state_e ACK_NEXT = ARMED;
`else
   localparam cmp_state_e ACK_NEXT = IDLE;
`endif

   cmp_state_e        state_q, state_d;
   logic              irq_q;
   logic [MISS_W-1:0] miss_q, miss_d;
   logic [LENGTH-1:0] cmp_q, cmp_d;
   logic              match;

   // Uses the compare value held this cycle, so a same-cycle load matches the old value.
   assign match = (count == cmp_q);

   always_ff @(posedge clk or negedge arst_b) begin
      if (!arst_b) begin
         state_q <= IDLE;
         irq_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         irq_q   <= (state_d == PENDING);
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arm && !disarm) state_d = ARMED;
         ARMED: begin
            if (disarm)     state_d = IDLE;
            else if (match) state_d = PENDING;
         end
         PENDING: begin
            if (disarm)       state_d = IDLE;
            else if (irq_ack) state_d = ACK_NEXT;
         end
         default:             state_d = IDLE;
      endcase
   end

   always_comb begin
      irq        = irq_q;
      state      = state_q;
      miss_count = miss_q;
   end

   // Disarm overrides a same-cycle match, so it does not count as a miss either.
   always_comb begin
      miss_d = miss_q;
      if (state_q == IDLE && arm && !disarm)
         miss_d = '0;
      else if (state_q == PENDING && match && !disarm && miss_q != MISS_MAX)
         miss_d = miss_q + 1'b1;
   end

`ifdef COUNT_CMP_AUTO_RELOAD_EN
   logic [LENGTH-1:0] period_q;

   always_comb begin
      cmp_d = cmp_q;
      if (cmp_load)
         cmp_d = cmp_value;
      else if (match && (state_q == ARMED || state_q == PENDING))
         cmp_d = cmp_q + period_q;
   end

   always_ff @(posedge clk or negedge arst_b) begin
      if (!arst_b)       period_q <= '0;
      else if (cmp_load) period_q <= cmp_value;
   end
`else
   always_comb begin
      cmp_d = cmp_load ? cmp_value : cmp_q;
   end
`endif

   always_ff @(posedge clk or negedge arst_b) begin
      if (!arst_b) begin
         miss_q <= '0;
         cmp_q  <= '0;
      end else begin
         miss_q <= miss_d;
         cmp_q  <= cmp_d;
      end
   end

   count_wrap_detect #(
      .LENGTH (LENGTH)
   ) u_wrap (
      .clk    (clk),
      .arst_b (arst_b),
      .count  (count),
      .wrap   (wrap)
   );

endmodule

// File: tb/tb_count_compare_irq.sv
// Scoreboard bench for count_compare_irq: driver pushes reference-model expectations, monitor checks.
module tb_count_compare_irq;

   localparam int LENGTH = 10;
   localparam int MISS_W = 4;
   localparam int CMAX   = (1 << LENGTH) - 1;
   localparam int MMAX   = (1 << MISS_W) - 1;

   logic              clk = 1'b0;
   logic              arst_b = 1'b0;
   logic [LENGTH-1:0] count = '0;
   logic [LENGTH-1:0] cmp_value = '0;
   logic              cmp_load = 1'b0;
   logic              arm = 1'b0;
   logic              disarm = 1'b0;
   logic              irq_ack = 1'b0;
   logic              irq;
   logic              wrap;
   logic [MISS_W-1:0] miss_count;
   logic [1:0]        state;

   count_compare_irq #(.LENGTH(LENGTH), .MISS_W(MISS_W)) dut (
      .clk        (clk),
      .arst_b     (arst_b),
      .count      (count),
      .cmp_value  (cmp_value),
      .cmp_load   (cmp_load),
      .arm        (arm),
      .disarm     (disarm),
      .irq_ack    (irq_ack),
      .irq        (irq),
      .wrap       (wrap),
      .miss_count (miss_count),
      .state      (state)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: plain integers, state as 0=idle 1=armed 2=pending.
   int m_st = 0, m_miss = 0, m_cmp = 0, m_per = 0, m_prev = 0;
   bit m_irq = 0, m_wrap = 0;

   typedef struct packed {
      logic       irq;
      logic       wrap;
      logic [3:0] miss;
      logic [1:0] st;
   } exp_t;
   exp_t exp_q[$];

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_step();
      bit m;
      int ns, nm, nc;
      if (!arst_b) begin
         m_st = 0; m_irq = 0; m_wrap = 0; m_miss = 0; m_cmp = 0; m_per = 0; m_prev = 0;
      end else begin
         m  = (int'(count) == m_cmp);
         ns = m_st;
         nm = m_miss;
         nc = m_cmp;
         if (m_st == 0) begin
            if (arm && !disarm) begin ns = 1; nm = 0; end
         end else if (disarm) begin
            ns = 0;
         end else if (m_st == 1) begin
            if (m) ns = 2;
         end else begin
            if (m && m_miss < MMAX) nm = m_miss + 1;
`ifdef COUNT_CMP_AUTO_RELOAD_EN
            if (irq_ack) ns = 1;
`else
            if (irq_ack) ns = 0;
`endif
         end
         if (cmp_load) nc = int'(cmp_value);
`ifdef COUNT_CMP_AUTO_RELOAD_EN
         else if (m && m_st != 0) nc = (m_cmp + m_per) % (CMAX + 1);
         if (cmp_load) m_per = int'(cmp_value);
`endif
         m_wrap = (m_prev == CMAX) && (count == 0);
         m_prev = int'(count);
         m_st   = ns;
         m_miss = nm;
         m_cmp  = nc;
         m_irq  = (ns == 2);
      end
   endtask

   task automatic push_exp();
      exp_t e;
      e.irq  = m_irq;
      e.wrap = m_wrap;
      e.miss = 4'(m_miss);
      e.st   = 2'(m_st);
      exp_q.push_back(e);
   endtask

   // One clock of stimulus: inputs already set at the negedge; strobes drop afterwards.
   task automatic cycle();
      model_step();
      push_exp();
      @(negedge clk);
      cmp_load = 1'b0; arm = 1'b0; disarm = 1'b0; irq_ack = 1'b0;
   endtask

   task automatic step_count(input int n);
      for (int i = 0; i < n; i++) begin
         count = count + 1'b1;
         cycle();
      end
   endtask

   task automatic goto_count(input int target);
      for (int i = 0; i <= CMAX && int'(count) != target; i++) begin
         count = count + 1'b1;
         cycle();
      end
   endtask

   task automatic async_reset();
      #2 arst_b = 1'b0;
      #1;
      check("async_irq", int'(irq), 0);
      check("async_state", int'(state), 0);
      check("async_miss", int'(miss_count), 0);
      model_step();
      push_exp();
      @(negedge clk);
      cmp_load = 1'b0; arm = 1'b0; disarm = 1'b0; irq_ack = 1'b0;
      arst_b = 1'b1;
   endtask

   initial begin : monitor
      exp_t e, a;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {irq, wrap, miss_count, state};
            n_chk++;
            if (a === e) n_pass++;
            else $display("FAIL scoreboard: got irq=%0b wrap=%0b miss=%0d st=%0d expected irq=%0b wrap=%0b miss=%0d st=%0d at %0t",
                          a.irq, a.wrap, a.miss, a.st, e.irq, e.wrap, e.miss, e.st, $time);
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      int r;
      repeat (3) @(negedge clk);
      check("rst_irq", int'(irq), 0);
      check("rst_wrap", int'(wrap), 0);
      check("rst_miss", int'(miss_count), 0);
      check("rst_state", int'(state), 0);
      arst_b = 1'b1;

      // Basic one-shot match at 5, ack, next pass silent; also crosses 1022->1023->0.
      count = '0; cmp_value = 10'd5; cmp_load = 1'b1; cycle();
      arm = 1'b1; cycle();
      step_count(8);
      irq_ack = 1'b1; cycle();
      goto_count(1022);
      step_count(10);

      // Upstream reset from 500 is not a wrap.
      count = 10'd500; cycle();
      count = 10'd0; cycle();
      cycle();

      // arm+disarm together stays idle.
      arm = 1'b1; disarm = 1'b1; cycle();
      // Pending then disarm.
      arm = 1'b1; count = 10'd2; cycle();
      goto_count(5); step_count(3);
      disarm = 1'b1; cycle();
      // Load 7 in the cycle count==5 still matches old value 5.
      count = 10'd1; arm = 1'b1; cycle();
      count = 10'd5; cmp_value = 10'd7; cmp_load = 1'b1; cycle();
      step_count(3);

      // Async reset in the middle of pending.
      disarm = 1'b1; cycle();
      cmp_value = 10'd5; cmp_load = 1'b1; cycle();
      arm = 1'b1; cycle();
      goto_count(6);
      async_reset();
      step_count(20);

      // Miss saturation: cmp 3, never ack for 20 wraps.
      cmp_value = 10'd3; cmp_load = 1'b1; cycle();
      arm = 1'b1; cycle();
      step_count(20 * (CMAX + 1));
      goto_count(2);
      count = 10'd3; irq_ack = 1'b1; cycle();
      step_count(4);

      // Ack coincident with match while unsaturated adds one miss.
      arm = 1'b1; cycle();
      goto_count(3); step_count(CMAX + 1);
      goto_count(2);
      count = 10'd3; irq_ack = 1'b1; cycle();
      step_count(4);

`ifdef COUNT_CMP_AUTO_RELOAD_EN
      disarm = 1'b1; count = '0; cycle();
      cmp_value = 10'd100; cmp_load = 1'b1; cycle();
      arm = 1'b1; cycle();
      for (int i = 0; i < 1200; i++) begin
         count = count + 1'b1;
         if (m_irq) irq_ack = 1'b1;
         cycle();
      end
`endif

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         if (i == 1000 || i == 2000) async_reset();
         r = int'($urandom_range(0, 99));
         if (r < 88)      count = count + 1'b1;
         else if (r < 93) count = '0;
         else if (r < 97) count = 10'd1022;
         else             count = LENGTH'($urandom_range(0, CMAX));
         if ($urandom_range(0, 19) == 0) begin
            cmp_load  = 1'b1;
            cmp_value = count + LENGTH'($urandom_range(0, 12));
         end
         arm     = ($urandom_range(0, 9) == 0);
         disarm  = ($urandom_range(0, 39) == 0);
         irq_ack = ($urandom_range(0, 7) == 0);
         cycle();
      end

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         n_chk++;
         $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
